// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter: FSM state type, double-dabble correction
//               constants and the digit-count legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } b2b_state_t;

  // A BCD nibble of 5 or more would carry past 9 once doubled, so it is
  // pre-corrected by +3 before the shift.
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Smallest number of decimal digits able to hold 2**width-1.
  function automatic int min_digits(input int width);
    longint max_val;
    longint pow10;
    int     d;
    max_val = (longint'(1) << width) - 1;
    pow10   = 1;
    d       = 0;
    while (pow10 <= max_val) begin
      pow10 = pow10 * 10;
      d     = d + 1;
    end
    if (d == 0) begin
      d = 1;
    end
    return d;
  endfunction

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational double-dabble correction for one BCD nibble:
//               adds 3 when the nibble is 5 or more, otherwise passes it on.
//               The sum wraps inside 4 bits; legal BCD inputs never overflow.
// Ports       : i_nibble [3:0]  nibble before correction
//               o_nibble [3:0]  nibble after correction
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_nibble = i_nibble;
    if (i_nibble >= ADJ_THRESH) begin
      o_nibble = i_nibble + ADJ_ADD;
    end
  end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative double-dabble binary-to-BCD converter. One shift
//               per clock; a conversion takes WIDTH cycles after the start
//               is accepted. Start/busy/valid handshake, registered outputs.
// Ports       : clk                 clock, rising edge
//               rst                 asynchronous reset, active low
//               start               conversion request, honoured when idle
//               bin   [WIDTH-1:0]   binary value, sampled on acceptance
//               busy                conversion in flight
//               valid               one-cycle pulse, bcd holds a new result
//               bcd   [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_sr_w  = c_bcd_w + WIDTH;
  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Too few digits would silently drop the top decimal digit of large inputs.
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS=%0d cannot represent 2**%0d-1", DIGITS, WIDTH);
  end

  b2b_state_t            state_q, state_d;
  logic [c_sr_w-1:0]     shreg_q, shreg_d;
  logic [c_cnt_w-1:0]    bitcnt_q, bitcnt_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [c_bcd_w-1:0]    bcd_q, bcd_d;

  logic [c_sr_w-1:0]     w_adjusted;
  logic [c_sr_w-1:0]     w_shifted;
  logic                  w_unused_msb;

  // Binary part is untouched by the correction; only the BCD field adjusts.
  assign w_adjusted[WIDTH-1:0] = shreg_q[WIDTH-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_nibble (shreg_q[WIDTH + 4*i +: 4]),
      .o_nibble (w_adjusted[WIDTH + 4*i +: 4])
    );
  end

  // The bit shifted out of the top is always zero when DIGITS is legal.
  assign w_shifted    = {w_adjusted[c_sr_w-2:0], 1'b0};
  assign w_unused_msb = w_adjusted[c_sr_w-1];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    bcd_d    = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = {{c_bcd_w{1'b0}}, bin};
          bitcnt_d = c_cnt_w'(WIDTH - 1);
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = w_shifted;
        if (bitcnt_q == '0) begin
          bcd_d   = w_shifted[c_sr_w-1 -: c_bcd_w];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          bitcnt_d = bitcnt_q - c_cnt_w'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      bcd_q    <= bcd_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign bcd   = bcd_q;

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
//               A behavioural model (decimal arithmetic plus a cycle count
//               to completion) is compared with the DUT every cycle; key
//               results are also pinned to literal BCD values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     bin;
  logic                 busy;
  logic                 valid;
  logic [4*DIGITS-1:0]  bcd;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .valid (valid),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by division, digit 0 in the low nibble.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a conversion completes WIDTH edges after acceptance.
  int                  m_left;
  int                  m_pending;
  logic                m_valid;
  logic [4*DIGITS-1:0] m_bcd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left    <= 0;
      m_pending <= 0;
      m_valid   <= 1'b0;
      m_bcd     <= '0;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
      m_valid <= (m_left == 1);
      if (m_left == 1) m_bcd <= to_bcd(m_pending);
    end else begin
      m_valid <= 1'b0;
      if (start) begin
        m_pending <= int'(bin);
        m_left    <= WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle{busy,valid,bcd}", {18'b0, busy, valid, bcd},
            {18'b0, (m_left > 0), m_valid, m_bcd});
    end
  end

  // Pulse start for one accepting edge; caller is positioned away from posedge.
  task automatic start_now(input logic [WIDTH-1:0] v);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = WIDTH'($urandom);
  endtask

  // Start a conversion, then measure latency/busy length and the result.
  task automatic convert_check(input logic [WIDTH-1:0] v, input logic [4*DIGITS-1:0] exp);
    int  n;
    int  nbusy;
    bit  seen;
    start_now(v);
    nbusy = 0;
    seen  = 1'b0;
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    check("valid_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      check("latency", n, WIDTH + 1);
      check("busy_cycles", nbusy, WIDTH);
      check("bcd_result", {20'b0, bcd}, {20'b0, exp});
    end
  endtask

  initial begin
    int vcount;
    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_bcd", {20'b0, bcd}, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk); #1;

    // Directed values with hand-computed BCD.
    convert_check(8'd255, 12'h255);
    @(negedge clk); #1;
    convert_check(8'd0, 12'h000);
    @(negedge clk); #1;
    convert_check(8'd99, 12'h099);
    @(negedge clk); #1;
    convert_check(8'd100, 12'h100);
    @(negedge clk); #1;

    // Start while busy is ignored.
    start_now(8'd128);
    repeat (3) @(negedge clk);
    #1 start_now(8'd7);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        vcount++;
        check("ignored_start_bcd", {20'b0, bcd}, 32'h128);
      end
    end
    check("ignored_start_pulses", vcount, 1);
    @(negedge clk); #1;

    // Back-to-back: second start in the valid cycle.
    convert_check(8'd128, 12'h128);
    #1 convert_check(8'd7, 12'h007);
    @(negedge clk); #1;

    // Reset mid-conversion aborts at once.
    start_now(8'd200);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_valid", {31'b0, valid}, 32'd0);
    check("abort_bcd", {20'b0, bcd}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    convert_check(8'd200, 12'h200);

    // Counter-driven sweep of every input value.
    for (int c = 0; c < (1 << WIDTH); c++) begin
      @(negedge clk); #1;
      convert_check(WIDTH'(c), to_bcd(c));
    end

    // Random start/bin traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      bin   = WIDTH'($urandom);
    end
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bin2bcd_seq
`default_nettype wire
